cbf_power_serializer: RTL and testbench



---
 rtl/cbf_power_serializer.sv | 238 +++++++++++++++++++++++
 tb/tb_cbf_power_serializer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbf_power_serializer.sv
// -----------------------------------------------------------------------------
// cbf_power_serializer
//   Width-down converter and packetiser for CBF power words on the DOA
//   transmit path. Each DATA_WIDTH-bit power word is sent as BYTES = DATA_WIDTH/8
//   bytes on an 8-bit AXI-stream. Words are grouped into UDP payloads: tlast
//   marks the last byte of a word that either carried s_axis_tlast or is
//   word MAX_WORDS_PER_PACKET of the current payload.
//
//   Optional feature (macro CBF_SERIALIZER_HEADER_EN): each payload starts
//   with a 2-byte big-endian sequence number that increments per payload.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   s_axis_tdata   input power word
//   s_axis_tvalid  input word valid
//   s_axis_tready  input word accepted (IDLE, or last-byte handshake cycle)
//   s_axis_tlast   last word of a scan; closes the payload
//   m_axis_tdata   payload byte (registered)
//   m_axis_tvalid  payload byte valid (registered)
//   m_axis_tready  downstream ready
//   m_axis_tlast   last byte of payload (registered)
//   m_axis_tuser   error flag, tied low
//   busy           high while a payload is partially sent
// -----------------------------------------------------------------------------
module cbf_power_serializer #(
  parameter int DATA_WIDTH           = 88,
  parameter int MAX_WORDS_PER_PACKET = 16,
  parameter bit MSB_FIRST            = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
);

  localparam int             BYTES    = DATA_WIDTH / 8;
  localparam int             BIW      = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BYTES - 1);
  localparam logic [BIW-1:0] IDX_ONE  = BIW'(1);
  localparam logic [7:0]     WC_LAST  = 8'(MAX_WORDS_PER_PACKET - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef CBF_SERIALIZER_HEADER_EN
    , HDR = 2'd2
`endif
  } state_t;

  // Next byte to send from a word, honouring the byte order.
  function automatic logic [7:0] head_byte(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) head_byte = w[DATA_WIDTH-1 -: 8];
    else           head_byte = w[7:0];
  endfunction

  // Remove the byte returned by head_byte so the next one moves into place.
  function automatic logic [DATA_WIDTH-1:0] drop_byte(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) drop_byte = w << 8;
    else           drop_byte = w >> 8;
  endfunction

  state_t                state;
  state_t                state_nxt;
  state_t                load_state;
  logic                  ready_en;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BIW-1:0]        byte_idx;
  logic [BIW-1:0]        idx_inc;
  logic [7:0]            word_cnt;
  logic [7:0]            word_cnt_nxt;
  logic                  last_q;
  logic [7:0]            tdata_q;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  m_hs;
  logic                  at_last;
  logic                  s_ready;
  logic                  s_hs;
  logic                  word_done;
`ifdef CBF_SERIALIZER_HEADER_EN
  logic [15:0]           seq;
  logic [15:0]           seq_nxt;
  logic                  hdr_start;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Handshake decode and counter look-ahead shared by next-state and datapath.
  always_comb begin
    m_hs      = tvalid_q & m_axis_tready;
    at_last   = (state == SHIFT) && (byte_idx == LAST_IDX);
    // ready_en keeps tready low until the first edge after reset release
    s_ready   = ready_en && ((state == IDLE) || (at_last && m_axis_tready));
    s_hs      = s_ready && s_axis_tvalid;
    word_done = at_last && m_hs;
    idx_inc   = byte_idx + IDX_ONE;
    if (word_done) begin
      if (tlast_q) word_cnt_nxt = 8'd0;
      else         word_cnt_nxt = word_cnt + 8'd1;
    end else begin
      word_cnt_nxt = word_cnt;
    end
`ifdef CBF_SERIALIZER_HEADER_EN
    if (word_done && tlast_q) seq_nxt = seq + 16'd1;
    else                      seq_nxt = seq;
    // a word loaded while the payload count is zero opens a new payload
    hdr_start  = (word_cnt_nxt == 8'd0);
    if (hdr_start) load_state = HDR;
    else           load_state = SHIFT;
`else
    load_state = SHIFT;
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_hs) state_nxt = load_state;
        else      state_nxt = IDLE;
      end
      SHIFT: begin
        if (word_done) begin
          if (s_hs) state_nxt = load_state;
          else      state_nxt = IDLE;
        end else begin
          state_nxt = SHIFT;
        end
      end
`ifdef CBF_SERIALIZER_HEADER_EN
      HDR: begin
        if (m_hs && (byte_idx == IDX_ONE)) state_nxt = SHIFT;
        else                               state_nxt = HDR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: shift register, byte index, payload counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en <= 1'b0;
      shreg    <= '0;
      byte_idx <= '0;
      word_cnt <= 8'd0;
      last_q   <= 1'b0;
      tdata_q  <= 8'd0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
`ifdef CBF_SERIALIZER_HEADER_EN
      seq      <= 16'd0;
`endif
    end else begin
      ready_en <= 1'b1;
      word_cnt <= word_cnt_nxt;
`ifdef CBF_SERIALIZER_HEADER_EN
      seq      <= seq_nxt;
`endif
      if (s_hs) begin
        // capture from IDLE or chain straight onto the last-byte handshake
        last_q   <= s_axis_tlast;
        byte_idx <= '0;
        tvalid_q <= 1'b1;
`ifdef CBF_SERIALIZER_HEADER_EN
        if (hdr_start) begin
          shreg   <= s_axis_tdata;
          tdata_q <= seq_nxt[15:8];
          tlast_q <= 1'b0;
        end else begin
          shreg   <= drop_byte(s_axis_tdata);
          tdata_q <= head_byte(s_axis_tdata);
          tlast_q <= (BYTES == 1) && (s_axis_tlast || (word_cnt_nxt == WC_LAST));
        end
`else
        shreg   <= drop_byte(s_axis_tdata);
        tdata_q <= head_byte(s_axis_tdata);
        tlast_q <= (BYTES == 1) && (s_axis_tlast || (word_cnt_nxt == WC_LAST));
`endif
      end else if (m_hs) begin
        case (state)
          SHIFT: begin
            if (byte_idx == LAST_IDX) begin
              tvalid_q <= 1'b0;
              tdata_q  <= 8'd0;
              tlast_q  <= 1'b0;
            end else begin
              byte_idx <= idx_inc;
              tdata_q  <= head_byte(shreg);
              shreg    <= drop_byte(shreg);
              tlast_q  <= (idx_inc == LAST_IDX) && (last_q || (word_cnt == WC_LAST));
            end
          end
`ifdef CBF_SERIALIZER_HEADER_EN
          HDR: begin
            if (byte_idx == '0) begin
              tdata_q  <= seq[7:0];
              byte_idx <= IDX_ONE;
            end else begin
              // header done: present data byte 0 of the held word
              byte_idx <= '0;
              tdata_q  <= head_byte(shreg);
              shreg    <= drop_byte(shreg);
              tlast_q  <= (BYTES == 1) && (last_q || (word_cnt == WC_LAST));
            end
          end
`endif
          default: begin
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = 1'b0;
  assign s_axis_tready = s_ready;
  assign busy          = (state != IDLE) || (word_cnt != 8'd0);

endmodule

// File: tb/tb_cbf_power_serializer.sv
module tb_cbf_power_serializer;

  localparam int DW    = 88;
  localparam int BYTES = DW / 8;
  localparam int MAXW  = 4;
  localparam bit MSBF  = 1'b1;
`ifdef CBF_SERIALIZER_HEADER_EN
  localparam int H = 2;
`else
  localparam int H = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          busy;

  cbf_power_serializer #(
    .DATA_WIDTH(DW), .MAX_WORDS_PER_PACKET(MAXW), .MSB_FIRST(MSBF)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .busy(busy)
  );

  initial forever #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 60) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected byte stream: {end_of_word, tlast, data}
  logic [9:0] q[$];
  logic [8:0] log_q[$];
  int         hs_cyc[$];
  int         vld_rise[$];
  int         pkt_pos = 0;
  int         wc_m = 0;
  logic [15:0] seq_m = 16'd0;
  bit         en_m = 1'b0;
  int         cyc = 0;
  int         bp_mode = 0;
  int         bp_cnt = 0;

  task automatic model_push(input logic [DW-1:0] w, input logic tl);
    bit is_last;
    logic [7:0] b;
    is_last = tl || (pkt_pos == MAXW - 1);
    if (H != 0 && pkt_pos == 0) begin
      q.push_back({2'b00, seq_m[15:8]});
      q.push_back({2'b00, seq_m[7:0]});
    end
    for (int i = 0; i < BYTES; i++) begin
      if (MSBF) b = w[DW-1-8*i -: 8];
      else      b = w[8*i +: 8];
      q.push_back({(i == BYTES - 1), (i == BYTES - 1) && is_last, b});
    end
    if (is_last) begin
      pkt_pos = 0;
      seq_m   = seq_m + 16'd1;
    end else begin
      pkt_pos = pkt_pos + 1;
    end
  endtask

  // Single compare process: checks every output against the model each cycle.
  initial begin
    logic [9:0] e;
    bit prev_vld;
    bit exp_rdy;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        q.delete();
        pkt_pos = 0; wc_m = 0; seq_m = 16'd0; en_m = 1'b0; prev_vld = 1'b0;
        check("rst_m_tvalid", 16'(m_axis_tvalid), 16'd0);
        check("rst_s_tready", 16'(s_axis_tready), 16'd0);
        check("rst_m_tdata",  16'(m_axis_tdata),  16'd0);
        check("rst_busy",     16'(busy),          16'd0);
      end else begin
        exp_rdy = en_m && ((q.size() == 0) || ((q.size() == 1) && m_axis_tready));
        check("s_tready", 16'(s_axis_tready), 16'(exp_rdy));
        check("m_tvalid", 16'(m_axis_tvalid), 16'(q.size() != 0));
        check("busy",     16'(busy),          16'((q.size() != 0) || (wc_m != 0)));
        check("m_tuser",  16'(m_axis_tuser),  16'd0);
        if (m_axis_tvalid && q.size() != 0) begin
          e = q[0];
          check("m_tdata", 16'(m_axis_tdata), 16'(e[7:0]));
          check("m_tlast", 16'(m_axis_tlast), 16'(e[8]));
          if (m_axis_tready) begin
            void'(q.pop_front());
            log_q.push_back({m_axis_tlast, m_axis_tdata});
            if (e[9]) wc_m = e[8] ? 0 : wc_m + 1;
          end
        end
        if (m_axis_tvalid && !prev_vld) vld_rise.push_back(cyc);
        prev_vld = m_axis_tvalid;
        if (s_axis_tvalid && s_axis_tready) begin
          hs_cyc.push_back(cyc);
          model_push(s_axis_tdata, s_axis_tlast);
        end
        en_m = 1'b1;
      end
    end
  end

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      bp_cnt++;
      case (bp_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ((bp_cnt % 4) == 0) || ((bp_cnt % 4) == 3);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_word(input logic [DW-1:0] d, input logic tl, input bit keep);
    int n;
    n = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = tl;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 500);
    check("send_timeout", 16'(n >= 500), 16'd0);
    @(posedge clk); #1;
    if (!keep) s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_axis_tvalid || s_axis_tvalid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 16'(n >= 2000), 16'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    log_q.delete();
    hs_cyc.delete();
    vld_rise.delete();
  endtask

  function automatic int count_tlast();
    int c;
    c = 0;
    foreach (log_q[i]) if (log_q[i][8]) c++;
    return c;
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    logic [95:0] rw;
    logic [7:0]  k;
    logic [8:0]  le;
    int          d;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single word, tlast=1
    clear_logs();
    send_word(88'h0102030405060708090A0B, 1'b1, 1'b0);
    wait_idle();
    check("t1_len", 16'(log_q.size()), 16'(11 + H));
    le = log_q[H];       check("t1_first", 16'(le[7:0]), 16'h0001);
    le = log_q[H + 10];  check("t1_last",  16'(le), 16'h010B);
    check("t1_ntlast", 16'(count_tlast()), 16'd1);
    d = vld_rise[0] - hs_cyc[0];
    check("t1_latency", 16'(d), 16'd1);

    // Back-to-back three words, tvalid held
    clear_logs();
    send_word(88'h0102030405060708090A0B, 1'b0, 1'b1);
    send_word(88'h1112131415161718191A1B, 1'b0, 1'b1);
    send_word(88'h2122232425262728292A2B, 1'b1, 1'b0);
    wait_idle();
    check("t2_len", 16'(log_q.size()), 16'(33 + H));
    check("t2_ntlast", 16'(count_tlast()), 16'd1);
    le = log_q[H + 32];  check("t2_lastbyte", 16'(le), 16'h012B);
    le = log_q[H + 11];  check("t2_word2", 16'(le), 16'h0011);
    check("t2_nhs", 16'(hs_cyc.size()), 16'd3);
    d = hs_cyc[1] - hs_cyc[0]; check("t2_gap1", 16'(d), 16'(11 + H));
    d = hs_cyc[2] - hs_cyc[1]; check("t2_gap2", 16'(d), 16'd11);
    check("t2_nrise", 16'(vld_rise.size()), 16'd1);

    // Forced split: 9 words, no tlast, MAX=4
    clear_logs();
    for (int i = 0; i < 9; i++) begin
      k = 8'h30 + 8'(i);
      send_word({11{k}}, 1'b0, (i != 8));
    end
    wait_idle();
    check("t3_len", 16'(log_q.size()), 16'(99 + 3 * H));
    check("t3_ntlast", 16'(count_tlast()), 16'd2);
    le = log_q[43 + H];      check("t3_tl1", 16'(le), 16'h0133);
    le = log_q[87 + 2 * H];  check("t3_tl2", 16'(le), 16'h0137);
    check("t3_busy", 16'(busy), 16'd1);

    // Async reset in the middle of a word
    send_word(88'hF0F1F2F3F4F5F6F7F8F9FA, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("ar_tvalid", 16'(m_axis_tvalid), 16'd0);
    check("ar_tdata",  16'(m_axis_tdata),  16'd0);
    check("ar_tlast",  16'(m_axis_tlast),  16'd0);
    check("ar_tready", 16'(s_axis_tready), 16'd0);
    check("ar_busy",   16'(busy),          16'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    send_word(88'hA1A2A3A4A5A6A7A8A9AAAB, 1'b1, 1'b0);
    wait_idle();
    check("ar_len", 16'(log_q.size()), 16'(11 + H));
    le = log_q[H];       check("ar_first", 16'(le), 16'h00A1);
    le = log_q[H + 10];  check("ar_lastb", 16'(le), 16'h01AB);

`ifdef CBF_SERIALIZER_HEADER_EN
    // Header sequence: first payload after reset carries 0, next carries 1
    le = log_q[0]; check("hd_p0_b0", 16'(le), 16'h0000);
    le = log_q[1]; check("hd_p0_b1", 16'(le), 16'h0000);
    clear_logs();
    send_word(88'h0102030405060708090A0B, 1'b1, 1'b0);
    wait_idle();
    check("hd_len", 16'(log_q.size()), 16'd13);
    le = log_q[0];  check("hd_p1_b0", 16'(le), 16'h0000);
    le = log_q[1];  check("hd_p1_b1", 16'(le), 16'h0001);
    le = log_q[12]; check("hd_p1_tl", 16'(le), 16'h010B);
`endif

    // Backpressure 1,0,0,1
    bp_mode = 1;
    clear_logs();
    send_word(88'h1112131415161718191A1B, 1'b0, 1'b1);
    send_word(88'h2122232425262728292A2B, 1'b1, 1'b0);
    wait_idle();
    check("bp_len", 16'(log_q.size()), 16'(22 + H));
    le = log_q[H];       check("bp_b0",  16'(le), 16'h0011);
    le = log_q[H + 11];  check("bp_b11", 16'(le), 16'h0021);
    le = log_q[H + 21];  check("bp_b21", 16'(le), 16'h012B);
    check("bp_ntlast", 16'(count_tlast()), 16'd1);

    // Random data, random tlast, random backpressure
    bp_mode = 2;
    for (int i = 0; i < 20; i++) begin
      rw = {$urandom, $urandom, $urandom};
      send_word(rw[DW-1:0], 1'($urandom_range(0, 3) == 0), (i != 19));
    end
    wait_idle();
    check("rnd_drained", 16'(q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
